vote_session_ctrl: RTL and testbench
====================================

Name: vote_session_ctrl

Overview:
Sequences one voting session for a 4-voter panel. It opens a ballot window and accepts exactly one vote per voter through a per-voter valid/ready handshake. It closes the window when all four have voted or a timeout expires, then evaluates the ballot with the panel's majority/tie rule. The registered result is held until the consumer acknowledges it. The block sits between the voter input front-ends and the result display/logging logic.

Parameters:
TIMEOUT_CYCLES, 200, number of COLLECT cycles before the window force-closes; legal range 1..2^CNT_W-1
CNT_W, 8, width of the window timer

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  open a new session; sampled only in IDLE
abort  input  1  cancel the session; no result is produced
vote_valid  input  4  per-voter vote strobe; bit i belongs to voter i
vote_val  input  4  per-voter ballot, 1=yes, 0=no; sampled with vote_valid
vote_ready  output  4  per-voter accept; high in COLLECT while voter i has not voted
busy  output  1  high in COLLECT, EVAL and RESULT
result_valid  output  1  result registers are valid; high only in RESULT
result_ack  input  1  consumer accepts the result
win  output  1  3 or more yes votes
tie  output  1  exactly 2 yes votes
yes_count  output  3  number of yes votes, 0..4
voted_mask  output  4  voters whose votes were accepted this session
timed_out  output  1  window closed by timeout, not by the full ballot
session_id  output  8  count of completed (acknowledged) sessions; wraps 255->0

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE.
  - All outputs are 0: vote_ready, busy, result_valid, win, tie, yes_count, voted_mask, timed_out, session_id.
  - The internal ballot register and the timer are 0.
- States and transitions: IDLE -> COLLECT -> EVAL -> RESULT -> IDLE.
- IDLE:
  - start=1 -> COLLECT.
  - On entry to COLLECT, clear ballot, voted_mask and timer.
  - start in any other state is ignored.
- COLLECT:
  - vote_ready[i] = ~voted_mask[i].
  - A vote is accepted when vote_valid[i] & vote_ready[i]: set voted_mask[i] and store ballot[i] = vote_val[i].
  - Several voters may be accepted in the same cycle.
  - vote_valid on an already-voted voter is ignored; the stored ballot is unchanged.
  - The timer increments every COLLECT cycle.
  - Leave to EVAL when the updated voted_mask is 4'b1111. Votes accepted in that cycle count.
  - Otherwise, leave to EVAL with timed_out<=1 when the timer equals TIMEOUT_CYCLES-1. Votes accepted in that cycle still count.
  - Missing voters count as "no".
  - If both the all-voted and timeout conditions hold in the same cycle, all-voted wins and timed_out=0.
- EVAL: one cycle, then RESULT.
  - Register yes_count = popcount(ballot).
  - win = (yes_count >= 3).
  - tie = (yes_count == 2).
  - win and tie are never both 1. 0 or 1 yes gives win=0, tie=0.
- RESULT:
  - result_valid=1, held until result_ack=1.
  - On result_ack, go to IDLE next cycle and increment session_id (modulo 256).
  - win, tie, yes_count, voted_mask and timed_out stay stable throughout RESULT.
  - They keep their values after returning to IDLE, until the next EVAL.
  - timed_out is cleared on entry to COLLECT.
- Latency: last vote accepted at cycle N -> EVAL at N+1 -> result_valid=1 at N+2. result_ack at cycle M -> IDLE and busy=0 at M+1.
- abort:
  - In COLLECT, EVAL or RESULT: go to IDLE next cycle.
  - result_valid drops and session_id does not increment.
  - abort has priority over votes, over the timeout, and over result_ack in the same cycle.
  - In IDLE, abort has priority over start: neither has any effect.
- vote_ready is 0 in all states except COLLECT.
- Reset asserted mid-session returns immediately to the reset state. No partial result is exposed.

Test Plan:
- Start; all four vote_valid=1 in one cycle with vote_val=4'b1011 -> EVAL the next cycle, result_valid two cycles after the vote. yes_count=3, win=1, tie=0, timed_out=0, voted_mask=1111.
- Staggered votes over 4 cycles with ballots 1,0,1,0; voter 0 re-strobes with vote_val=0 after voting -> vote_ready[0]=0 and the re-strobe is ignored. Result: yes_count=2, tie=1, win=0.
- TIMEOUT_CYCLES=5; only voter 2 votes yes -> window closes after 5 COLLECT cycles. Result: timed_out=1, voted_mask=0100, yes_count=1, win=0, tie=0.
- Hold result_ack=0 for 10 cycles in RESULT -> result_valid and all result fields stable. Then ack -> busy=0 next cycle and session_id 0->1. Repeat 256 sessions -> session_id wraps to 0.
- abort during COLLECT with 2 votes taken -> IDLE next cycle, no result_valid pulse, session_id unchanged. abort and result_ack in the same cycle -> session_id unchanged.
- Assert rst_n=0 asynchronously while in RESULT -> all outputs 0 immediately, without waiting for a clock edge. After release, start works normally.

Source files
------------

// File: rtl/vote_session_ctrl.sv
// Voting session sequencer for a 4-voter panel: collects one ballot per voter,
// closes on full ballot or timeout, evaluates majority/tie and holds the result until acked.
module vote_session_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 200,
  parameter int unsigned CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [3:0]       vote_valid,
  input  logic [3:0]       vote_val,
  output logic [3:0]       vote_ready,
  output logic             busy,
  output logic             result_valid,
  input  logic             result_ack,
  output logic             win,
  output logic             tie,
  output logic [2:0]       yes_count,
  output logic [3:0]       voted_mask,
  output logic             timed_out,
  output logic [7:0]       session_id
);

  localparam int unsigned NV = 4;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_EVAL, S_RESULT} state_e;

  state_e           state_q, state_d;
  logic [NV-1:0]    ballot_q, ballot_d;
  logic [NV-1:0]    voted_mask_q, voted_mask_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [NV-1:0]    vote_ready_q, vote_ready_d;
  logic             busy_q, busy_d;
  logic             result_valid_q, result_valid_d;
  logic             win_q, win_d;
  logic             tie_q, tie_d;
  logic [2:0]       yes_count_q, yes_count_d;
  logic             timed_out_q, timed_out_d;
  logic [7:0]       session_id_q, session_id_d;
  logic [NV-1:0]    accept;
  logic [2:0]       yes_sum;

  function automatic logic [2:0] popcount4(input logic [NV-1:0] v);
    logic [2:0] s;
    s = 3'd0;
    for (int i = 0; i < NV; i++) s = s + 3'(v[i]);
    return s;
  endfunction

  // Next-state, ballot capture and result evaluation
  always_comb begin
    state_d        = state_q;
    ballot_d       = ballot_q;
    voted_mask_d   = voted_mask_q;
    timer_d        = timer_q;
    win_d          = win_q;
    tie_d          = tie_q;
    yes_count_d    = yes_count_q;
    timed_out_d    = timed_out_q;
    session_id_d   = session_id_q;
    accept         = '0;
    yes_sum        = popcount4(ballot_q);

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d      = S_COLLECT;
          ballot_d     = '0;
          voted_mask_d = '0;
          timer_d      = '0;
          timed_out_d  = 1'b0;
        end
      end
      S_COLLECT: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          accept       = vote_valid & ~voted_mask_q;
          voted_mask_d = voted_mask_q | accept;
          ballot_d     = (ballot_q & ~accept) | (vote_val & accept);
          timer_d      = timer_q + CNT_W'(1);
          // Full ballot takes precedence over a coincident timeout
          if (voted_mask_d == 4'b1111) begin
            state_d = S_EVAL;
          end else if (timer_q == TMO_LAST) begin
            state_d     = S_EVAL;
            timed_out_d = 1'b1;
          end
        end
      end
      S_EVAL: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          yes_count_d = yes_sum;
          win_d       = (yes_sum >= 3'd3);
          tie_d       = (yes_sum == 3'd2);
          state_d     = S_RESULT;
        end
      end
      S_RESULT: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (result_ack) begin
          state_d      = S_IDLE;
          session_id_d = session_id_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    vote_ready_d   = (state_d == S_COLLECT) ? ~voted_mask_d : '0;
    busy_d         = (state_d != S_IDLE);
    result_valid_d = (state_d == S_RESULT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      ballot_q       <= '0;
      voted_mask_q   <= '0;
      timer_q        <= '0;
      vote_ready_q   <= '0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
      win_q          <= 1'b0;
      tie_q          <= 1'b0;
      yes_count_q    <= '0;
      timed_out_q    <= 1'b0;
      session_id_q   <= '0;
    end else begin
      state_q        <= state_d;
      ballot_q       <= ballot_d;
      voted_mask_q   <= voted_mask_d;
      timer_q        <= timer_d;
      vote_ready_q   <= vote_ready_d;
      busy_q         <= busy_d;
      result_valid_q <= result_valid_d;
      win_q          <= win_d;
      tie_q          <= tie_d;
      yes_count_q    <= yes_count_d;
      timed_out_q    <= timed_out_d;
      session_id_q   <= session_id_d;
    end
  end

  assign vote_ready   = vote_ready_q;
  assign busy         = busy_q;
  assign result_valid = result_valid_q;
  assign win          = win_q;
  assign tie          = tie_q;
  assign yes_count    = yes_count_q;
  assign voted_mask   = voted_mask_q;
  assign timed_out    = timed_out_q;
  assign session_id   = session_id_q;

endmodule

// File: tb/tb_vote_session_ctrl.sv
// Scoreboard bench for vote_session_ctrl: expected ballots are modelled as votes are
// driven and compared when the result appears.
module tb_vote_session_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, abort, result_ack;
  logic [3:0] vote_valid, vote_val, vote_ready, voted_mask;
  logic       busy, result_valid, win, tie, timed_out;
  logic [2:0] yes_count;
  logic [7:0] session_id;

  typedef struct packed {
    logic [2:0] yes;
    logic       win;
    logic       tie;
    logic       to;
    logic [3:0] mask;
  } exp_t;

  exp_t       sb_q[$];
  logic [3:0] m_mask, m_ballot;
  logic [7:0] exp_sid;
  int         n_checks = 0;
  int         n_fail   = 0;

  vote_session_ctrl #(.TIMEOUT_CYCLES(5), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .vote_valid(vote_valid), .vote_val(vote_val), .vote_ready(vote_ready),
    .busy(busy), .result_valid(result_valid), .result_ack(result_ack),
    .win(win), .tie(tie), .yes_count(yes_count), .voted_mask(voted_mask),
    .timed_out(timed_out), .session_id(session_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic open_session();
    m_mask   = '0;
    m_ballot = '0;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  // First accepted vote per voter wins; later strobes are ignored
  task automatic drive_votes(input logic [3:0] valid, input logic [3:0] val);
    vote_valid = valid;
    vote_val   = val;
    for (int i = 0; i < 4; i++) begin
      if (valid[i] && !m_mask[i]) begin
        m_mask[i]   = 1'b1;
        m_ballot[i] = val[i];
      end
    end
    tick();
    vote_valid = '0;
    vote_val   = '0;
  endtask

  task automatic push_expect(input logic to);
    exp_t e;
    int   y;
    y      = $countones(m_ballot);
    e.yes  = 3'(y);
    e.win  = (y >= 3);
    e.tie  = (y == 2);
    e.to   = to;
    e.mask = m_mask;
    sb_q.push_back(e);
  endtask

  task automatic cmp_fields(input string tag, input exp_t e);
    chk({tag, "_yes"},  32'(yes_count),  32'(e.yes));
    chk({tag, "_win"},  32'(win),        32'(e.win));
    chk({tag, "_tie"},  32'(tie),        32'(e.tie));
    chk({tag, "_to"},   32'(timed_out),  32'(e.to));
    chk({tag, "_mask"}, 32'(voted_mask), 32'(e.mask));
  endtask

  task automatic pop_compare(input string tag, output exp_t e);
    for (int i = 0; i < 50 && !result_valid; i++) tick();
    e = '0;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'(0), 32'(1));
    end else begin
      e = sb_q.pop_front();
      if (!result_valid) chk({tag, "_result_timeout"}, 32'(0), 32'(1));
      else cmp_fields(tag, e);
    end
  endtask

  task automatic ack_session(input string tag);
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
    exp_sid    = exp_sid + 8'd1;
    chk({tag, "_busy_after_ack"}, 32'(busy), 32'(0));
    chk({tag, "_sid"}, 32'(session_id), 32'(exp_sid));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, 32'(vote_ready), 32'(0));
    chk({tag, "_busy"},  32'(busy), 32'(0));
    chk({tag, "_rv"},    32'(result_valid), 32'(0));
    chk({tag, "_fields"}, 32'({win, tie, yes_count, voted_mask, timed_out}), 32'(0));
    chk({tag, "_sid"},   32'(session_id), 32'(0));
  endtask

  initial begin
    exp_t e;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; result_ack = 1'b0;
    vote_valid = '0; vote_val = '0; exp_sid = '0;
    m_mask = '0; m_ballot = '0;
    repeat (2) tick();
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Full ballot in one cycle: EVAL next, result two cycles after the vote
    open_session();
    chk("t1_busy", 32'(busy), 32'(1));
    chk("t1_ready", 32'(vote_ready), 32'hF);
    drive_votes(4'b1111, 4'b1011);
    push_expect(1'b0);
    chk("t1_eval_rv", 32'(result_valid), 32'(0));
    chk("t1_eval_ready", 32'(vote_ready), 32'(0));
    tick();
    chk("t1_result_rv", 32'(result_valid), 32'(1));
    pop_compare("t1", e);
    ack_session("t1");

    // Staggered votes with a re-strobe from voter 0
    open_session();
    drive_votes(4'b0001, 4'b0001);
    chk("t2_ready_after_v0", 32'(vote_ready), 32'b1110);
    drive_votes(4'b0011, 4'b0000);
    drive_votes(4'b0100, 4'b0100);
    drive_votes(4'b1000, 4'b0000);
    push_expect(1'b0);
    pop_compare("t2", e);
    ack_session("t2");

    // Timeout after 5 COLLECT cycles, then hold the result for 10 cycles
    open_session();
    drive_votes(4'b0100, 4'b0100);
    repeat (3) tick();
    chk("t3_still_collect", 32'(vote_ready), 32'b1011);
    tick();
    chk("t3_closed_ready", 32'(vote_ready), 32'(0));
    chk("t3_eval_rv", 32'(result_valid), 32'(0));
    push_expect(1'b1);
    pop_compare("t3", e);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t4_hold_rv", 32'(result_valid), 32'(1));
      cmp_fields("t4_hold", e);
    end
    ack_session("t4");

    // Abort in COLLECT with two votes taken
    open_session();
    drive_votes(4'b0011, 4'b0011);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t5_abort_busy", 32'(busy), 32'(0));
    chk("t5_abort_ready", 32'(vote_ready), 32'(0));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_no_rv", 32'(result_valid), 32'(0));
    end
    chk("t5_sid", 32'(session_id), 32'(exp_sid));

    // Abort and start together in IDLE: nothing happens
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("t5_idle_abort_busy", 32'(busy), 32'(0));

    // Abort and ack in the same cycle
    open_session();
    drive_votes(4'b1111, 4'b0110);
    push_expect(1'b0);
    pop_compare("t5b", e);
    abort = 1'b1; result_ack = 1'b1;
    tick();
    abort = 1'b0; result_ack = 1'b0;
    chk("t5b_busy", 32'(busy), 32'(0));
    chk("t5b_rv", 32'(result_valid), 32'(0));
    chk("t5b_sid", 32'(session_id), 32'(exp_sid));

    // Run sessions until session_id wraps to 0
    while (exp_sid != 8'd0) begin
      open_session();
      drive_votes(4'b1111, 4'($urandom_range(0, 15)));
      push_expect(1'b0);
      pop_compare("wrap", e);
      ack_session("wrap");
    end
    chk("wrap_zero", 32'(session_id), 32'(0));

    // Asynchronous reset while in RESULT
    open_session();
    drive_votes(4'b1111, 4'b1111);
    push_expect(1'b0);
    pop_compare("t6", e);
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("t6_async");
    exp_sid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    open_session();
    chk("t6_restart_busy", 32'(busy), 32'(1));
    drive_votes(4'b1111, 4'b0001);
    push_expect(1'b0);
    pop_compare("t6b", e);
    ack_session("t6b");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
